// File: rtl/pll_reset_sequencer.sv
// Power-up and recovery sequencer for the rPLL: pulses PLL reset, filters lock,
// waits a settle interval, then releases the downstream system reset.
module pll_reset_sequencer #(
  parameter int RST_CYCLES    = 27,
  parameter int LOCK_TIMEOUT  = 27000,
  parameter int SETTLE_CYCLES = 2700,
  parameter int LOCK_FILTER   = 4,
  parameter int MAX_RETRY     = 3,
  parameter int CNT_W         = 16
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       rearm,
  output logic       pll_reset,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [2:0] state,
  output logic [7:0] lock_loss_cnt
);

  localparam int FILT_W  = $clog2(LOCK_FILTER + 1);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [FILT_W-1:0]  FILT_LAST    = FILT_W'(LOCK_FILTER - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    RST_PLL   = 3'd0,
    WAIT_LOCK = 3'd1,
    SETTLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_e;

  state_e             st, st_nxt;
  logic [CNT_W-1:0]   interval_cnt;
  logic [FILT_W-1:0]  filt_cnt, filt_nxt;
  logic [RETRY_W-1:0] retry_cnt, retry_nxt;
  logic [7:0]         loss_nxt;
  logic [1:0]         lock_sync;
  logic               lock_s;
  logic               attempt_fail;

  assign lock_s = lock_sync[1];
  assign state  = st;

  // Two-flop synchroniser; pll_lock is asynchronous to clkin.
  always_ff @(posedge clkin) begin
    if (reset) lock_sync <= '0;
    else       lock_sync <= {lock_sync[0], pll_lock};
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    st_nxt       = st;
    retry_nxt    = retry_cnt;
    loss_nxt     = lock_loss_cnt;
    filt_nxt     = '0;
    attempt_fail = 1'b0;

    case (st)
      RST_PLL: begin
        if (interval_cnt == RST_LAST) st_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        filt_nxt = lock_s ? filt_cnt + FILT_W'(1) : '0;
        // Lock acceptance beats a coincident timeout.
        if (lock_s && filt_cnt == FILT_LAST)  st_nxt = SETTLE;
        else if (interval_cnt == TIMEOUT_LAST) attempt_fail = 1'b1;
      end
      SETTLE: begin
        if (!lock_s) begin
          attempt_fail = 1'b1;
        end else if (interval_cnt == SETTLE_LAST) begin
          st_nxt    = RUN;
          retry_nxt = '0;
        end
      end
      RUN: begin
        if (!lock_s) begin
          st_nxt = RST_PLL;
          if (lock_loss_cnt != 8'hff) loss_nxt = lock_loss_cnt + 8'd1;
        end
      end
      FAULT: begin
        if (rearm) begin
          st_nxt    = RST_PLL;
          retry_nxt = '0;
        end
      end
      default: st_nxt = RST_PLL;
    endcase

    if (attempt_fail) begin
      retry_nxt = retry_cnt + RETRY_W'(1);
      st_nxt    = (retry_nxt == RETRY_LIMIT) ? FAULT : RST_PLL;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as state.
  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clkin) begin
    if (reset) begin
      st            <= RST_PLL;
      interval_cnt  <= '0;
      filt_cnt      <= '0;
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
      pll_reset     <= 1'b1;
      sys_rst       <= 1'b1;
      ready         <= 1'b0;
      fault         <= 1'b0;
    end else begin
      st            <= st_nxt;
      interval_cnt  <= (st_nxt != st) ? '0 : interval_cnt + CNT_W'(1);
      filt_cnt      <= filt_nxt;
      retry_cnt     <= retry_nxt;
      lock_loss_cnt <= loss_nxt;
      pll_reset     <= (st_nxt == RST_PLL) || (st_nxt == FAULT);
      sys_rst       <= (st_nxt != RUN);
      ready         <= (st_nxt == RUN);
      fault         <= (st_nxt == FAULT);
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small intervals; cycle k is the
// sample taken #1 after edge k-1 following reset release (cycle 0 precedes edge 0).
module tb_pll_reset_sequencer;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int SETTLE_CYCLES = 8;
  localparam int LOCK_FILTER   = 3;
  localparam int MAX_RETRY     = 2;
  localparam int CNT_W         = 16;

  logic       clkin    = 1'b0;
  logic       reset    = 1'b1;
  logic       pll_lock = 1'b0;
  logic       rearm    = 1'b0;
  logic       pll_reset, sys_rst, ready, fault;
  logic [2:0] state;
  logic [7:0] lock_loss_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pll_reset_sequencer #(
    .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT), .SETTLE_CYCLES(SETTLE_CYCLES),
    .LOCK_FILTER(LOCK_FILTER), .MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W)
  ) dut (
    .clkin(clkin), .reset(reset), .pll_lock(pll_lock), .rearm(rearm),
    .pll_reset(pll_reset), .sys_rst(sys_rst), .ready(ready), .fault(fault),
    .state(state), .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clkin = ~clkin;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  task automatic apply_reset(input logic lock);
    pll_lock = lock;
    reset    = 1'b1;
    tick(3);
    reset    = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " state"},     state,         0);
    check({tag, " pll_reset"}, pll_reset,     1);
    check({tag, " sys_rst"},   sys_rst,       1);
    check({tag, " ready"},     ready,         0);
    check({tag, " fault"},     fault,         0);
    check({tag, " llc"},       lock_loss_cnt, 0);
  endtask

  task automatic wait_ready(input logic val, input int bound, input string tag);
    int n = 0;
    while (ready !== val && n < bound) begin
      tick(1);
      n++;
    end
    check(tag, ready, val);
  endtask

  task automatic wait_state(input logic [2:0] val, input int bound, input string tag);
    int n = 0;
    while (state !== val && n < bound) begin
      tick(1);
      n++;
    end
    check(tag, state, val);
  endtask

  // Expected state with pll_lock high from reset: RST 0-3, WAIT 4-6, SETTLE 7-14, RUN 15+.
  function automatic int exp_clean(input int k);
    if (k < 4)  return 0;
    if (k < 7)  return 1;
    if (k < 15) return 2;
    return 3;
  endfunction

  // Expected state with pll_lock low: two 4+20 attempts, then FAULT at cycle 48.
  function automatic int exp_nolock(input int k);
    if (k < 4)  return 0;
    if (k < 24) return 1;
    if (k < 28) return 0;
    if (k < 48) return 1;
    return 4;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // Clean bring-up, including values held while reset is asserted.
    pll_lock = 1'b1;
    reset    = 1'b1;
    tick(3);
    check_reset_values("s1 in reset");
    reset = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      check($sformatf("s1 state c%0d", k),     state,     exp_clean(k));
      check($sformatf("s1 pll_reset c%0d", k), pll_reset, (k < 4)  ? 1 : 0);
      check($sformatf("s1 sys_rst c%0d", k),   sys_rst,   (k < 15) ? 1 : 0);
      check($sformatf("s1 ready c%0d", k),     ready,     (k >= 15) ? 1 : 0);
      tick(1);
    end

    // Late lock: rises at cycle 14, SETTLE 5 edges later at cycle 19, RUN at cycle 27.
    apply_reset(1'b0);
    tick(14);
    check("s2 wait c14", state, 1);
    pll_lock = 1'b1;
    tick(4);
    check("s2 wait c18", state, 1);
    tick(1);
    check("s2 settle c19", state, 2);
    tick(7);
    check("s2 settle c26", state, 2);
    check("s2 ready c26", ready, 0);
    tick(1);
    check("s2 run c27", state, 3);
    check("s2 ready c27", ready, 1);
    check("s2 sys_rst c27", sys_rst, 0);
    check("s2 pll_reset c27", pll_reset, 0);

    // Timeout twice into FAULT, then rearm restarts with retry count cleared.
    apply_reset(1'b0);
    for (int k = 0; k < 50; k++) begin
      check($sformatf("s3 state c%0d", k), state, exp_nolock(k));
      if (k == 48) begin
        check("s3 fault", fault, 1);
        check("s3 pll_reset", pll_reset, 1);
        check("s3 sys_rst", sys_rst, 1);
        check("s3 ready", ready, 0);
      end
      tick(1);
    end
    tick(5);
    check("s3 fault hold", state, 4);
    rearm = 1'b1;
    tick(1);
    rearm = 1'b0;
    check("s3 rearm state", state, 0);
    check("s3 rearm fault", fault, 0);
    check("s3 rearm pll_reset", pll_reset, 1);
    tick(24);
    check("s3 rearm retry1", state, 0);
    tick(24);
    check("s3 rearm refault", state, 4);

    // Lock filter: a 2-cycle pulse is rejected and the attempt still times out on
    // schedule; a 3-cycle pulse reaches SETTLE, whose lock drop then exhausts retries.
    apply_reset(1'b0);
    tick(4);
    pll_lock = 1'b1;
    tick(2);
    pll_lock = 1'b0;
    tick(4);
    check("s4 short pulse c10", state, 1);
    tick(13);
    check("s4 still waiting c23", state, 1);
    tick(1);
    check("s4 timeout c24", state, 0);
    tick(4);
    check("s4 retry wait c28", state, 1);
    pll_lock = 1'b1;
    tick(3);
    pll_lock = 1'b0;
    check("s4 filtering c31", state, 1);
    tick(2);
    check("s4 settle c33", state, 2);
    tick(1);
    check("s4 settle drop fault c34", state, 4);
    check("s4 fault flag c34", fault, 1);

    // Lock loss in RUN: drop at cycle 15, outputs react at cycle 18; then saturation.
    apply_reset(1'b1);
    tick(15);
    check("s5 run", state, 3);
    pll_lock = 1'b0;
    tick(2);
    check("s5 ready c17", ready, 1);
    tick(1);
    check("s5 ready c18", ready, 0);
    check("s5 sys_rst c18", sys_rst, 1);
    check("s5 state c18", state, 0);
    check("s5 llc c18", lock_loss_cnt, 1);
    pll_lock = 1'b1;
    tick(14);
    check("s5 relock c32", ready, 0);
    tick(1);
    check("s5 relock c33", ready, 1);
    check("s5 relock llc", lock_loss_cnt, 1);
    for (int i = 2; i <= 256; i++) begin
      pll_lock = 1'b0;
      tick(1);
      pll_lock = 1'b1;
      wait_ready(1'b0, 10, $sformatf("s5 loss %0d", i));
      wait_ready(1'b1, 40, $sformatf("s5 relock %0d", i));
      if (i == 255) check("s5 llc 255", lock_loss_cnt, 255);
    end
    check("s5 llc saturated", lock_loss_cnt, 255);

    // Mid-sequence reset during SETTLE clears everything, then the clean sequence repeats.
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    wait_ready(1'b0, 10, "s6 leave run");
    wait_state(3'd2, 30, "s6 reach settle");
    tick(2);
    check("s6 in settle", state, 2);
    reset = 1'b1;
    tick(1);
    check_reset_values("s6 after reset");
    reset = 1'b0;
    for (int k = 0; k <= 15; k++) begin
      check($sformatf("s6 state c%0d", k), state, exp_clean(k));
      tick(1);
    end
    check("s6 ready", ready, 1);
    check("s6 llc", lock_loss_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Power-up and recovery sequencer for the on-chip rPLL that clocks the TM1638 driver logic. Runs on the 27 MHz board input clock. It pulses the PLL reset, waits for a filtered lock, then waits a settle interval before releasing the downstream system reset. It retries on lock timeout, latches a fault after repeated failures, and re-sequences automatically on lock loss.

Parameters:
RST_CYCLES, 27, cycles pll_reset is held high per attempt (1 us at 27 MHz); must be >=1
LOCK_TIMEOUT, 27000, cycles allowed in WAIT_LOCK before the attempt fails (1 ms)
SETTLE_CYCLES, 2700, cycles of stable lock required before sys_rst is released (100 us)
LOCK_FILTER, 4, consecutive synchronised lock-high samples required to accept lock; must be >=1
MAX_RETRY, 3, failed attempts before entering FAULT; must be >=1
CNT_W, 16, width of the shared interval counter; must hold max(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES)

Ports:
clkin  input  1  27 MHz reference clock; sole clock of the block
reset  input  1  synchronous, active-high reset
pll_lock  input  1  PLL LOCK output, asynchronous to clkin; double-flop synchronised internally
rearm  input  1  single-cycle pulse; in FAULT, restarts sequencing; ignored in all other states
pll_reset  output  1  drives PLL RESET, active-high
sys_rst  output  1  synchronous active-high reset for the clkout/clkoutd domains' reset synchronisers
ready  output  1  high only in RUN
fault  output  1  high only in FAULT
state  output  3  current state code, for debug
lock_loss_cnt  output  8  number of RUN-to-lock-loss events; saturates at 255

Behaviour:
- Reset values: state=RST_PLL(0), pll_reset=1, sys_rst=1, ready=0, fault=0, lock_loss_cnt=0, retry_cnt=0, interval counter=0, filter counter=0, sync flops=0. Reset takes priority over everything.
- All outputs are registered and decoded from state: pll_reset=1 in RST_PLL and FAULT; sys_rst=0 only in RUN; ready=(state==RUN); fault=(state==FAULT).
- lock_s is pll_lock after two flops, so there are 2 cycles of synchroniser latency.
- States and codes: RST_PLL=0, WAIT_LOCK=1, SETTLE=2, RUN=3, FAULT=4. Unused codes go to RST_PLL on the next cycle.
- The interval counter clears on every state change. Otherwise it increments once per cycle.
- RST_PLL: stays for exactly RST_CYCLES cycles, then goes to WAIT_LOCK. The filter counter is cleared here.
- WAIT_LOCK:
  - The filter counter increments while lock_s=1 and clears when lock_s=0.
  - When lock_s=1 and the filter counter equals LOCK_FILTER-1, go to SETTLE.
  - Otherwise, when the interval counter equals LOCK_TIMEOUT-1, the attempt fails: retry_cnt+1.
  - If the new retry_cnt equals MAX_RETRY, go to FAULT; else go to RST_PLL.
  - If lock acceptance and timeout fall in the same cycle, lock wins.
- SETTLE:
  - If lock_s=0 on any cycle, go to RST_PLL and count a failed attempt, with the same FAULT rule as WAIT_LOCK.
  - When the interval counter equals SETTLE_CYCLES-1 with lock_s=1, go to RUN and clear retry_cnt.
- RUN:
  - On lock_s=0, go to RST_PLL. sys_rst and ready change on the next edge, 1 cycle after lock_s falls.
  - lock_loss_cnt increments, saturating at 255.
  - retry_cnt is not incremented.
- FAULT:
  - Holds until reset or rearm=1.
  - rearm goes to RST_PLL, clears retry_cnt and keeps lock_loss_cnt.
- Release latency from reset deassertion, with pll_lock constantly high: RST_CYCLES + LOCK_FILTER + SETTLE_CYCLES cycles until sys_rst=0. The synchroniser is already filled during RST_PLL.
- A glitch on pll_lock shorter than LOCK_FILTER cycles in WAIT_LOCK restarts the filter without restarting the attempt.
- No combinational path from pll_lock to any output.

Test Plan:
Bench parameters for all scenarios: RST_CYCLES=4, LOCK_TIMEOUT=20, SETTLE_CYCLES=8, LOCK_FILTER=3, MAX_RETRY=2.
1. Clean bring-up: pll_lock=1 throughout, reset released at cycle 0 -> pll_reset high for cycles 0-3; sys_rst falls and ready rises at cycle 15; state codes follow 0,1,2,3.
2. Late lock: pll_lock rises 10 cycles into WAIT_LOCK -> SETTLE entered 2+3 cycles later; no retry; ready after a further 8 cycles.
3. Timeout/fault: pll_lock=0 -> WAIT_LOCK lasts 20 cycles; second RST_PLL pulse of 4 cycles; after the second timeout state=4, fault=1, pll_reset=1, sys_rst=1. A rearm pulse then gives state=0 next cycle with fault=0.
4. Lock filter: in WAIT_LOCK, drive a 2-cycle lock pulse then low -> stays in WAIT_LOCK and eventually times out. A 3-cycle pulse -> SETTLE.
5. Lock loss in RUN: drop pll_lock -> ready=0 and sys_rst=1 at 3 cycles after the drop (2 sync + 1); lock_loss_cnt=1; re-lock returns to RUN. 256 repeats leave lock_loss_cnt=255.
6. Mid-sequence reset: assert reset during SETTLE -> next cycle all outputs equal reset values and lock_loss_cnt=0; the sequence restarts as in scenario 1.
